// File: rtl/ret_addr_stack.sv
// ret_addr_stack: return-address LIFO feeding the PC load path.
// Macro RET_ADDR_STACK_WRAP_EN: a push when full overwrites the oldest entry.
module ret_addr_stack #(
   parameter int AW    = 16,
   parameter int DEPTH = 8,
   parameter int PW    = 3
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          push,
   input  logic          pop,
   input  logic          err_clr,
   input  logic [AW-1:0] pc_in,
   output logic [AW-1:0] ret_addr,
   output logic          pc_ld,
   output logic [PW:0]   count,
   output logic          empty,
   output logic          full,
   output logic          ovf_err,
   output logic          unf_err
);

   localparam logic [PW:0] LP_FULL = (PW+1)'(DEPTH);

   logic [AW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_sp;
   logic [PW:0]   r_cnt;
   logic [AW-1:0] r_ret;
   logic          r_ld;
   logic          r_ovf;
   logic          r_unf;

   logic [PW-1:0] w_top;
   logic          w_empty;
   logic          w_full;
   logic          w_wr;
   logic [PW-1:0] w_wr_idx;
   logic [PW-1:0] w_sp_nxt;
   logic [PW:0]   w_cnt_nxt;
   logic          w_ld;
   logic          w_ovf_set;
   logic          w_unf_set;

   assign w_top   = r_sp - 1'b1;
   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == LP_FULL);

   always_comb begin
      w_wr      = 1'b0;
      w_wr_idx  = r_sp;
      w_sp_nxt  = r_sp;
      w_cnt_nxt = r_cnt;
      w_ld      = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      unique case (1'b1)
         (pop && !w_empty): begin
            w_ld = 1'b1;
            if (push) begin
               // replace top: return old top, store new one in place
               w_wr     = 1'b1;
               w_wr_idx = w_top;
            end else begin
               w_sp_nxt  = w_top;
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         (pop && w_empty): begin
            w_unf_set = 1'b1;
            if (push) begin
               w_wr      = 1'b1;
               w_sp_nxt  = r_sp + 1'b1;
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         (push && !pop && !w_full): begin
            w_wr      = 1'b1;
            w_sp_nxt  = r_sp + 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
         end
         (push && !pop && w_full): begin
`ifdef RET_ADDR_STACK_WRAP_EN
            w_wr     = 1'b1;
            w_sp_nxt = r_sp + 1'b1;
`else
            w_ovf_set = 1'b1;
`endif
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_b && w_wr) begin
         r_mem[w_wr_idx] <= pc_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_sp  <= '0;
         r_cnt <= '0;
         r_ret <= '0;
         r_ld  <= 1'b0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         r_sp  <= w_sp_nxt;
         r_cnt <= w_cnt_nxt;
         r_ld  <= w_ld;
         if (w_ld) begin
            r_ret <= r_mem[w_top];
         end
         // a new error event outranks err_clr
         r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
         r_unf <= w_unf_set | (r_unf & ~err_clr);
      end
   end

   assign ret_addr = r_ret;
   assign pc_ld    = r_ld;
   assign count    = r_cnt;
   assign empty    = w_empty;
   assign full     = w_full;
   assign ovf_err  = r_ovf;
   assign unf_err  = r_unf;

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: directed and random stimulus against a queue-based
// reference; a monitor checks every cycle's outputs from an expectation queue.
module tb_ret_addr_stack;

   localparam int AW    = 16;
   localparam int DEPTH = 8;
   localparam int PW    = 3;

   logic          clk;
   logic          rst_b;
   logic          push;
   logic          pop;
   logic          err_clr;
   logic [AW-1:0] pc_in;
   logic [AW-1:0] ret_addr;
   logic          pc_ld;
   logic [PW:0]   count;
   logic          empty;
   logic          full;
   logic          ovf_err;
   logic          unf_err;

   ret_addr_stack #(.AW(AW), .DEPTH(DEPTH), .PW(PW)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .push     (push),
      .pop      (pop),
      .err_clr  (err_clr),
      .pc_in    (pc_in),
      .ret_addr (ret_addr),
      .pc_ld    (pc_ld),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .ovf_err  (ovf_err),
      .unf_err  (unf_err)
   );

   typedef struct {
      bit          ld;
      logic [15:0] ret;
      int          cnt;
      bit          ovf;
      bit          unf;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] stk[$];
   logic [15:0] m_ret;
   bit          m_ovf;
   bit          m_unf;
   int          n_chk;
   int          n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: stack as a queue, top at the back
   task automatic step(input bit r, input bit pu, input bit po,
                       input bit cl, input logic [15:0] pc);
      exp_t e;
      bit   ld;
      bit   os;
      bit   us;
      rst_b   = r;
      push    = pu;
      pop     = po;
      err_clr = cl;
      pc_in   = pc;
      ld = 0;
      os = 0;
      us = 0;
      if (!r) begin
         stk.delete();
         m_ret = 16'h0;
         m_ovf = 0;
         m_unf = 0;
      end else begin
         if (po && stk.size() > 0) begin
            m_ret = stk[stk.size()-1];
            ld = 1;
            if (pu) stk[stk.size()-1] = pc;
            else void'(stk.pop_back());
         end else if (po) begin
            us = 1;
            if (pu) stk.push_back(pc);
         end else if (pu) begin
            if (stk.size() < DEPTH) begin
               stk.push_back(pc);
            end else begin
`ifdef RET_ADDR_STACK_WRAP_EN
               void'(stk.pop_front());
               stk.push_back(pc);
`else
               os = 1;
`endif
            end
         end
         m_ovf = os | (m_ovf & !cl);
         m_unf = us | (m_unf & !cl);
      end
      e.ld  = ld;
      e.ret = m_ret;
      e.cnt = stk.size();
      e.ovf = m_ovf;
      e.unf = m_unf;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pc_ld", pc_ld, e.ld);
         chk("ret_addr", ret_addr, e.ret);
         chk("count", count, e.cnt);
         chk("empty", empty, e.cnt == 0);
         chk("full", full, e.cnt == DEPTH);
         chk("ovf_err", ovf_err, e.ovf);
         chk("unf_err", unf_err, e.unf);
      end
   end

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      m_ret   = 16'h0;
      m_ovf   = 0;
      m_unf   = 0;
      rst_b   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      err_clr = 1'b0;
      pc_in   = '0;
      @(negedge clk);
      step(0, 0, 0, 0, 16'h0);
      // T1: reset mid-sequence with three entries
      step(1, 1, 0, 0, 16'hAAA1);
      step(1, 1, 0, 0, 16'hAAA2);
      step(1, 1, 0, 0, 16'hAAA3);
      step(1, 0, 1, 0, 16'h0);
      step(1, 1, 0, 0, 16'hAAA4);
      step(0, 1, 1, 0, 16'hBBBB);
      step(0, 0, 0, 0, 16'h0);
      step(1, 0, 0, 0, 16'h0);
      // T2: LIFO order
      step(1, 1, 0, 0, 16'h0010);
      step(1, 1, 0, 0, 16'h0020);
      step(1, 1, 0, 0, 16'h0030);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 16'h0);
      step(1, 0, 0, 0, 16'h0);
      // T3: underflow, then clear
      step(1, 0, 1, 0, 16'h0);
      step(1, 0, 0, 0, 16'h0);
      step(1, 0, 0, 1, 16'h0);
      step(1, 0, 0, 0, 16'h0);
      step(1, 1, 1, 0, 16'h5555);
      step(1, 0, 1, 1, 16'h0);
      step(1, 0, 1, 1, 16'h0);
      step(1, 0, 0, 1, 16'h0);
      // T4: replace top
      step(1, 1, 0, 0, 16'h1111);
      step(1, 1, 1, 0, 16'h2222);
      step(1, 0, 1, 0, 16'h0);
      step(1, 0, 0, 0, 16'h0);
      // T5/T6: overfill, replace while full, drain
      for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 16'h0100 + 16'(i));
      step(1, 0, 0, 0, 16'h0);
      step(1, 1, 0, 1, 16'h0109);
      step(1, 1, 1, 0, 16'h0200);
      for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 16'h0);
      step(1, 0, 0, 1, 16'h0);
      // random traffic with phases biased toward fill and drain
      for (int i = 0; i < 3000; i++) begin
         int ph;
         bit pu;
         bit po;
         ph = (i / 100) % 3;
         pu = (ph == 0) ? ($urandom_range(0, 3) != 0) :
              (ph == 1) ? ($urandom_range(0, 3) == 0) :
                          $urandom_range(0, 1) == 1;
         po = (ph == 0) ? ($urandom_range(0, 3) == 0) :
              (ph == 1) ? ($urandom_range(0, 3) != 0) :
                          $urandom_range(0, 1) == 1;
         step($urandom_range(0, 199) != 0, pu, po,
              $urandom_range(0, 9) == 0, 16'($urandom));
      end
      step(1, 0, 0, 0, 16'h0);
      chk("leftover", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
